uart_apb_sequencer: RTL and testbench
=====================================

// Module: uart_apb_sequencer
// PURPOSE
//  Hardware APB master that configures one APB UART slave and then services it autonomously.
//  After cfg_start it writes the baud divider and control register. It then loops:
//  poll STATUS, drain RX bytes to a valid-only output, push TX bytes from a valid/ready input, clear overrun flags.
//  It replaces CPU/testbench APB task sequences in the UART subsystem.
// PARAMETERS
//  BASE_WADDR  10'h000   word address (PADDR[11:2]) of slave; regs at +0 DATA,+1 STATUS,+2 CTRL,+4 BAUDDIV
//  CTRL_VAL    7'h3F     value written to CTRL (TX/RX enable + interrupt enables)
//  BAUD_DIV    19'h00010 value written to BAUDDIV (zero-extended to 32b)
//  POLL_GAP    4         idle cycles between end of one service pass and next STATUS read (>=0)
// PORTS
//  PCLK        in   1   single clock
//  PRESETn     in   1   reset; synchronous and active-low
//  cfg_start   in   1   1-cycle pulse: begin config; ignored unless state==IDLE
//  tx_valid    in   1   TX byte request; held until tx_ready
//  tx_data     in   8   TX byte; stable while tx_valid
//  tx_ready    out  1   1-cycle pulse: DATA write for tx_data completed
//  rx_valid    out  1   1-cycle pulse: rx_data holds byte read from DATA
//  rx_data     out  8   received byte; holds until next rx_valid
//  cfg_done    out  1   high from completion of CTRL write until reset
//  ovr_err     out  1   1-cycle pulse when STATUS[3:2]!=0 was seen
//  slv_err     out  1   sticky: any transfer completed with PSLVERR=1; cleared only by reset
//  PSEL        out  1   APB select
//  PENABLE     out  1   APB enable
//  PWRITE      out  1   APB direction, 1=write
//  PADDR       out  10  APB word address [11:2]
//  PWDATA      out  32  APB write data
//  PRDATA      in   32  APB read data
//  PREADY      in   1   APB ready
//  PSLVERR     in   1   APB error
// BEHAVIOUR
//  Reset (PRESETn==0 at PCLK edge): state IDLE; all outputs 0, including PADDR and PWDATA.
//   Mid-transfer reset drops PSEL/PENABLE on that edge; no completion pulse issued.
//  APB engine: SETUP cycle (PSEL=1, PENABLE=0) -> ACCESS (PENABLE=1), held until PREADY=1.
//   PADDR/PWRITE/PWDATA stable SETUP through ACCESS.
//   PRDATA sampled and PSLVERR checked at the ACCESS edge where PREADY=1.
//   Next SETUP may begin the cycle after completion; minimum 2 cycles per transfer.
//   PSLVERR=1: set slv_err, sequence continues unchanged.
//  FSM main states: IDLE -> CFG_BAUD -> CFG_CTRL -> POLL -> {RD_DATA | WR_DATA | CLR_OVR} -> GAP -> POLL.
//   IDLE: wait for cfg_start.
//   CFG_BAUD: write BAUD_DIV to BASE+4.
//   CFG_CTRL: write CTRL_VAL to BASE+2; set cfg_done on completion.
//   POLL: read STATUS (BASE+1). Bits used: [0] TX full, [1] RX full, [2] TX ovr, [3] RX ovr.
//    At most one service action per pass; priority CLR_OVR > RD_DATA > WR_DATA.
//    None applicable: go to GAP.
//   CLR_OVR: pulse ovr_err at POLL completion; write {28'b0,STATUS[3:2],2'b00} to BASE+1 (W1C).
//   RD_DATA: read BASE+0; on completion rx_data<=PRDATA[7:0], rx_valid=1 for 1 cycle.
//   WR_DATA: taken only if tx_valid && !STATUS[0]; write {24'b0,tx_data} to BASE+0.
//    tx_ready pulses the cycle after completion; tx_valid low at POLL: skip TX.
//   GAP: count POLL_GAP cycles (0 = straight to POLL).
//  rx_valid and tx_ready never assert in the same cycle.
//  cfg_start outside IDLE: no effect. tx_valid before cfg_done: held pending, not lost.
// TESTING
//  1. Reset, cfg_start; slave PREADY=1 -> writes (0x004,0x10) then (0x002,0x3F), 2 cycles each; cfg_done high.
//  2. Slave STATUS=0x2, DATA=0xAB -> STATUS read, DATA read; rx_valid 1 cycle with rx_data=0xAB; no TX transfer.
//  3. tx_valid, tx_data=0x34, STATUS=0x0 -> write (0x000,0x34); tx_ready 1 cycle; STATUS=0x1 -> no write until it clears.
//  4. STATUS=0xC -> ovr_err pulse; write (0x001,0xC); next pass no clear issued when STATUS=0.
//  5. PREADY low 3 ACCESS cycles with PSLVERR=1 on completion -> PENABLE held 4 cycles; slv_err sticks; loop continues.
//  6. PRESETn low during ACCESS of WR_DATA -> PSEL/PENABLE 0 next edge; no tx_ready; IDLE; cfg_done=0.

Source files
------------

// File: rtl/uart_apb_sequencer_if.sv
// APB bus between the UART sequencer (master) and one APB UART slave.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : driven by the master
//   PRDATA/PREADY/PSLVERR            : driven by the slave
// PADDR is the word address (byte address bits [11:2]).
interface uart_apb_sequencer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/uart_apb_sequencer.sv
// Autonomous APB master for one UART slave. On cfg_start it writes BAUDDIV
// and CTRL, then loops forever: read STATUS, perform at most one service
// action (clear overrun, drain one RX byte, or push one TX byte), idle for
// POLL_GAP cycles, and poll again.
// Ports:
//   PCLK, PRESETn     clock, synchronous active-low reset
//   apb               APB master side (uart_apb_sequencer_if.master)
//   cfg_start         pulse, starts configuration from IDLE only
//   tx_valid/tx_data  TX byte request, held until tx_ready
//   tx_ready          pulse, the DATA write for tx_data completed
//   rx_valid/rx_data  pulse + byte read from DATA (rx_data holds)
//   cfg_done          high once CTRL write has completed
//   ovr_err           pulse, STATUS reported TX/RX overrun
//   slv_err           sticky, some transfer completed with PSLVERR
module uart_apb_sequencer #(
    parameter logic [9:0]  BASE_WADDR = 10'h000,
    parameter logic [6:0]  CTRL_VAL   = 7'h3F,
    parameter logic [18:0] BAUD_DIV   = 19'h00010,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    uart_apb_sequencer_if.master        apb,
    input  logic                        cfg_start,
    input  logic                        tx_valid,
    input  logic [7:0]                  tx_data,
    output logic                        tx_ready,
    output logic                        rx_valid,
    output logic [7:0]                  rx_data,
    output logic                        cfg_done,
    output logic                        ovr_err,
    output logic                        slv_err
);

    typedef enum logic [2:0] {
        IDLE, CFG_BAUD, CFG_CTRL, POLL, RD_DATA, WR_DATA, CLR_OVR, GAP
    } state_t;

    localparam int GAP_W = $clog2(POLL_GAP + 2);
    localparam logic [GAP_W-1:0] GAP_LAST = (POLL_GAP == 0) ? '0 : GAP_W'(POLL_GAP - 1);
    // Where a finished service pass goes: straight back to POLL when no gap.
    localparam state_t REST = (POLL_GAP == 0) ? POLL : GAP;

    localparam logic [9:0] ADDR_DATA = BASE_WADDR;
    localparam logic [9:0] ADDR_STAT = BASE_WADDR + 10'd1;
    localparam logic [9:0] ADDR_CTRL = BASE_WADDR + 10'd2;
    localparam logic [9:0] ADDR_BAUD = BASE_WADDR + 10'd4;

    state_t           state, state_nxt;
    logic             access, access_nxt;   // 0 = SETUP phase, 1 = ACCESS phase
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [31:0]      wdata_q;              // payload for WR_DATA / CLR_OVR
    logic             in_xfer;
    logic             xfer_done;

    assign in_xfer   = (state != IDLE) && (state != GAP);
    assign xfer_done = in_xfer && access && apb.PREADY;

    // State register
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state   <= IDLE;
            access  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            access  <= access_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        access_nxt  = access;
        gap_cnt_nxt = '0;
        case (state)
            IDLE: begin
                if (cfg_start) state_nxt = CFG_BAUD;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = POLL;
                else                     gap_cnt_nxt = gap_cnt + 1'b1;
            end
            default: begin
                if (!access) begin
                    access_nxt = 1'b1;
                end else if (apb.PREADY) begin
                    access_nxt = 1'b0;
                    case (state)
                        CFG_BAUD: state_nxt = CFG_CTRL;
                        CFG_CTRL: state_nxt = POLL;
                        POLL: begin
                            // One action per pass: overrun clear beats RX beats TX.
                            if (|apb.PRDATA[3:2])                 state_nxt = CLR_OVR;
                            else if (apb.PRDATA[1])               state_nxt = RD_DATA;
                            else if (tx_valid && !apb.PRDATA[0])  state_nxt = WR_DATA;
                            else                                  state_nxt = REST;
                        end
                        default:  state_nxt = REST;
                    endcase
                end
            end
        endcase
    end

    // APB output decode; address and data are fixed for the whole transfer
    // because they depend only on the state, which holds through ACCESS.
    always_comb begin
        apb.PSEL    = in_xfer;
        apb.PENABLE = in_xfer && access;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        case (state)
            CFG_BAUD: begin
                apb.PWRITE = 1'b1;
                apb.PADDR  = ADDR_BAUD;
                apb.PWDATA = {13'b0, BAUD_DIV};
            end
            CFG_CTRL: begin
                apb.PWRITE = 1'b1;
                apb.PADDR  = ADDR_CTRL;
                apb.PWDATA = {25'b0, CTRL_VAL};
            end
            POLL:    apb.PADDR = ADDR_STAT;
            RD_DATA: apb.PADDR = ADDR_DATA;
            WR_DATA: begin
                apb.PWRITE = 1'b1;
                apb.PADDR  = ADDR_DATA;
                apb.PWDATA = wdata_q;
            end
            CLR_OVR: begin
                apb.PWRITE = 1'b1;
                apb.PADDR  = ADDR_STAT;
                apb.PWDATA = wdata_q;
            end
            default: ;
        endcase
    end

    // Completion side effects: pulses, captured data, sticky flags
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            cfg_done <= 1'b0;
            ovr_err  <= 1'b0;
            slv_err  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            ovr_err  <= 1'b0;
            if (xfer_done) begin
                if (apb.PSLVERR) slv_err <= 1'b1;
                case (state)
                    CFG_CTRL: cfg_done <= 1'b1;
                    POLL: begin
                        if (|apb.PRDATA[3:2]) begin
                            ovr_err <= 1'b1;
                            wdata_q <= {28'b0, apb.PRDATA[3:2], 2'b00};
                        end else if (!apb.PRDATA[1] && tx_valid && !apb.PRDATA[0]) begin
                            wdata_q <= {24'b0, tx_data};
                        end
                    end
                    RD_DATA: begin
                        rx_data  <= apb.PRDATA[7:0];
                        rx_valid <= 1'b1;
                    end
                    WR_DATA: tx_ready <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
module tb_uart_apb_sequencer;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       cfg_start = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid, cfg_done, ovr_err, slv_err;
    logic [7:0] rx_data;

    uart_apb_sequencer_if bus ();

    uart_apb_sequencer dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .apb       (bus),
        .cfg_start (cfg_start),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cfg_done  (cfg_done),
        .ovr_err   (ovr_err),
        .slv_err   (slv_err)
    );

    always #5 PCLK = ~PCLK;

    // Slave model
    logic [31:0] status_val = 32'h0;
    logic [31:0] data_val   = 32'h0;
    int          wait_states = 0;
    logic        err_flag = 1'b0;
    int          acc_cnt = 0;

    assign bus.PREADY  = (acc_cnt >= wait_states);
    assign bus.PSLVERR = err_flag && bus.PREADY;
    assign bus.PRDATA  = (bus.PADDR == 10'h001) ? status_val :
                         (bus.PADDR == 10'h000) ? data_val : 32'h0;

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else                                         acc_cnt <= 0;
    end

    // Transfer log and pulse counters, sampled at the active edge
    logic [41:0] wr_q[$];
    int poll_cnt = 0, rx_cnt = 0, tx_cnt = 0, ovr_cnt = 0, both_cnt = 0;
    int pen_run = 0, pen_max = 0;

    always @(posedge PCLK) begin
        if (PRESETn && bus.PSEL && bus.PENABLE && bus.PREADY) begin
            if (bus.PWRITE)                wr_q.push_back({bus.PADDR, bus.PWDATA});
            else if (bus.PADDR == 10'h001) poll_cnt++;
        end
        if (rx_valid) rx_cnt++;
        if (tx_ready) tx_cnt++;
        if (ovr_err)  ovr_cnt++;
        if (rx_valid && tx_ready) both_cnt++;
        if (bus.PENABLE) begin
            pen_run++;
            if (pen_run > pen_max) pen_max = pen_run;
        end else begin
            pen_run = 0;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge PCLK);
    endtask

    initial begin
        int n;
        int wr_base, rx_base, tx_base, ovr_base, poll_base;

        // Reset state
        tick(3);
        check("rst_psel",    bus.PSEL, 0);
        check("rst_penable", bus.PENABLE, 0);
        check("rst_paddr",   bus.PADDR, 0);
        check("rst_pwdata",  bus.PWDATA, 0);
        check("rst_outs",    {cfg_done, slv_err, rx_valid, tx_ready, ovr_err}, 0);

        // Configuration writes, 2 cycles each
        PRESETn = 1'b1;
        tick(1);
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        check("baud_setup", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, {3'b101, 10'h004, 32'h10});
        tick(1);
        check("baud_access", {bus.PSEL, bus.PENABLE, bus.PADDR}, {2'b11, 10'h004});
        tick(1);
        check("ctrl_setup", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, {3'b101, 10'h002, 32'h3F});
        check("cfg_done_pre", cfg_done, 0);
        tick(1);
        check("ctrl_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        tick(1);
        check("cfg_done", cfg_done, 1);
        check("poll_setup", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}, {3'b100, 10'h001});
        check("cfg_writes", wr_q.size(), 2);
        check("cfg_wr0", wr_q[0], {10'h004, 32'h10});
        check("cfg_wr1", wr_q[1], {10'h002, 32'h3F});

        // cfg_start outside IDLE is ignored
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        tick(20);
        check("restart_ignored", wr_q.size(), 2);

        // RX drain
        wr_base = wr_q.size();
        rx_base = rx_cnt;
        status_val = 32'h2;
        data_val   = 32'hAB;
        n = 0;
        while (!rx_valid && n < 60) begin tick(1); n++; end
        status_val = 32'h0;
        check("rx_seen", rx_valid, 1);
        check("rx_data", rx_data, 8'hAB);
        tick(1);
        check("rx_pulse_1cyc", rx_valid, 0);
        tick(30);
        check("rx_count", rx_cnt - rx_base, 1);
        check("rx_no_tx_write", wr_q.size(), wr_base);
        check("rx_data_hold", rx_data, 8'hAB);

        // TX push
        tx_base = tx_cnt;
        tx_data  = 8'h34;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 60) begin tick(1); n++; end
        tx_valid = 1'b0;
        check("tx_seen", tx_ready, 1);
        check("tx_write", wr_q[$], {10'h000, 32'h34});
        tick(1);
        check("tx_pulse_1cyc", tx_ready, 0);
        check("tx_count", tx_cnt - tx_base, 1);

        // TX blocked while TX FIFO full
        wr_base = wr_q.size();
        tx_base = tx_cnt;
        status_val = 32'h1;
        tx_data  = 8'h56;
        tx_valid = 1'b1;
        tick(30);
        check("tx_full_no_write", wr_q.size(), wr_base);
        check("tx_full_no_ready", tx_cnt, tx_base);
        status_val = 32'h0;
        n = 0;
        while (!tx_ready && n < 60) begin tick(1); n++; end
        tx_valid = 1'b0;
        check("tx_after_full", wr_q[$], {10'h000, 32'h56});
        check("tx_after_full_cnt", wr_q.size(), wr_base + 1);

        // Overrun clear
        wr_base  = wr_q.size();
        ovr_base = ovr_cnt;
        status_val = 32'hC;
        n = 0;
        while (!ovr_err && n < 60) begin tick(1); n++; end
        status_val = 32'h0;
        check("ovr_seen", ovr_err, 1);
        tick(1);
        check("ovr_pulse_1cyc", ovr_err, 0);
        tick(40);
        check("ovr_count", ovr_cnt - ovr_base, 1);
        check("ovr_clear_count", wr_q.size(), wr_base + 1);
        check("ovr_clear_write", wr_q[$], {10'h001, 32'hC});
        check("no_rx_tx_overlap", both_cnt, 0);

        // Wait states with slave error
        check("slv_err_clean", slv_err, 0);
        poll_base = poll_cnt;
        pen_max = 0;
        wait_states = 3;
        err_flag = 1'b1;
        n = 0;
        while (!slv_err && n < 60) begin tick(1); n++; end
        err_flag = 1'b0;
        wait_states = 0;
        check("slv_err_set", slv_err, 1);
        tick(40);
        check("slv_err_sticky", slv_err, 1);
        check("penable_4cyc", pen_max, 4);
        check("loop_continues", (poll_cnt - poll_base) > 2, 1);

        // Reset in the ACCESS phase of a TX write
        wr_base = wr_q.size();
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        n = 0;
        while (!(bus.PENABLE && bus.PWRITE && bus.PADDR == 10'h000) && n < 60) begin tick(1); n++; end
        check("wr_access_seen", {bus.PENABLE, bus.PWRITE, bus.PADDR}, {2'b11, 10'h000});
        PRESETn = 1'b0;
        tx_base = tx_cnt;
        tick(1);
        check("rst_mid_bus", {bus.PSEL, bus.PENABLE}, 2'b00);
        check("rst_mid_flags", {cfg_done, tx_ready, slv_err}, 3'b000);
        tick(1);
        check("rst_mid_no_write", wr_q.size(), wr_base);
        check("rst_mid_no_ready", tx_cnt, tx_base);
        PRESETn = 1'b1;
        tick(5);
        check("idle_after_rst", {bus.PSEL, cfg_done}, 2'b00);

        // Pending TX request survives reconfiguration
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        n = 0;
        while (!tx_ready && n < 80) begin tick(1); n++; end
        tx_valid = 1'b0;
        check("pending_tx_ready", tx_ready, 1);
        check("reconfig_count", wr_q.size(), wr_base + 3);
        check("reconfig_baud", wr_q[wr_base], {10'h004, 32'h10});
        check("pending_tx_write", wr_q[$], {10'h000, 32'h77});
        check("cfg_done_again", cfg_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
